hybrid_jump_sequencer: RTL and testbench

HYBRID_JUMP_SEQUENCER -- requirements
Module: hybrid_jump_sequencer

---
 rtl/hybrid_jump_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_hybrid_jump_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hybrid_jump_sequencer.sv
// Hybrid-jump MOSFET sequencer: dead-time, dwell and armed jump control.
// Optional watchdog forced jump is built when HYBRID_JUMP_WATCHDOG_EN is defined.
module hybrid_jump_sequencer #(
  parameter int unsigned DEADTIME  = 10,
  parameter int unsigned MIN_DWELL = 100,
  parameter int unsigned WDT_LIMIT = 5000
) (
  input  logic       i_clock,
  input  logic       i_RESET,
  input  logic       i_enable,
  input  logic [3:0] i_jump_req,
  input  logic       i_skip_zero,
  output logic [3:0] o_MOSFET,
  output logic [1:0] o_sigma,
  output logic [1:0] o_mode,
  output logic       o_busy,
  output logic       o_wdt_flag
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEAD,
    S_DWELL,
    S_ARMED
  } state_e;

  localparam logic [15:0] DT_LAST = 16'(DEADTIME - 1);
  localparam logic [15:0] DW_LAST = 16'(MIN_DWELL - 1);

  if (DEADTIME < 1 || DEADTIME > 255 ||
      MIN_DWELL < 1 || MIN_DWELL > 65535 ||
      WDT_LIMIT < 1 || WDT_LIMIT > 65535) begin : g_bad_param
    $error("hybrid_jump_sequencer: parameter out of range");
  end

  function automatic logic [3:0] pat_f(input logic [1:0] m);
    case (m)
      2'd0:    pat_f = 4'b1001;
      2'd1:    pat_f = 4'b0011;
      2'd2:    pat_f = 4'b0110;
      default: pat_f = 4'b0011;
    endcase
  endfunction

  function automatic logic [1:0] sig_f(input logic [1:0] m);
    case (m)
      2'd0:    sig_f = 2'b01;
      2'd2:    sig_f = 2'b11;
      default: sig_f = 2'b00;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  tgt_q, tgt_d;
  logic        pend_q, pend_d;
  logic [3:0]  mos_q, mos_d;
  logic [1:0]  sig_q, sig_d;
  logic        busy_q, busy_d;
  logic [15:0] cnt_q, cnt_d;

`ifdef HYBRID_JUMP_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(WDT_LIMIT - 1);
  logic wdt_q, wdt_d;
`endif

  // Next-state and registered-output logic; disable beats everything else.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tgt_d   = tgt_q;
    pend_d  = pend_q;
    mos_d   = mos_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
`ifdef HYBRID_JUMP_WATCHDOG_EN
    wdt_d   = wdt_q;
`endif
    if (!i_enable) begin
      state_d = S_IDLE;
      mode_d  = 2'd0;
      tgt_d   = 2'd0;
      pend_d  = 1'b0;
      mos_d   = 4'b0000;
      sig_d   = 2'b00;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_DEAD;
          mode_d  = 2'd0;
          mos_d   = 4'b0000;
          sig_d   = sig_f(2'd0);
          cnt_d   = '0;
        end
        S_DEAD: begin
          if (cnt_q == DT_LAST) begin
            state_d = S_DWELL;
            mos_d   = pat_f(mode_q);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_DWELL: begin
          if (cnt_q == DW_LAST) begin
            state_d = S_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_ARMED: begin
          if (pend_q) begin
            state_d = S_DEAD;
            mode_d  = tgt_q;
            mos_d   = mos_q & pat_f(tgt_q);
            sig_d   = sig_f(tgt_q);
            pend_d  = 1'b0;
            cnt_d   = '0;
          end else if (i_jump_req[mode_q]) begin
            pend_d = 1'b1;
            tgt_d  = mode_q + (i_skip_zero ? 2'd2 : 2'd1);
            cnt_d  = '0;
`ifdef HYBRID_JUMP_WATCHDOG_EN
          end else if (cnt_q == WD_LAST) begin
            pend_d = 1'b1;
            tgt_d  = mode_q + 2'd1;
            wdt_d  = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_DEAD);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      tgt_q   <= 2'd0;
      pend_q  <= 1'b0;
      mos_q   <= 4'b0000;
      sig_q   <= 2'b00;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef HYBRID_JUMP_WATCHDOG_EN
      wdt_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      mos_q   <= mos_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
`ifdef HYBRID_JUMP_WATCHDOG_EN
      wdt_q   <= wdt_d;
`endif
    end
  end

  assign o_MOSFET = mos_q;
  assign o_sigma  = sig_q;
  assign o_mode   = mode_q;
  assign o_busy   = busy_q;
`ifdef HYBRID_JUMP_WATCHDOG_EN
  assign o_wdt_flag = wdt_q;
`else
  assign o_wdt_flag = 1'b0;
`endif

endmodule

// File: tb/tb_hybrid_jump_sequencer.sv
// Directed bench for hybrid_jump_sequencer (DEADTIME=4, MIN_DWELL=8, WDT_LIMIT=20).
// Watchdog expectations follow HYBRID_JUMP_WATCHDOG_EN.
module tb_hybrid_jump_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic       skip;
  logic [3:0] mos;
  logic [1:0] sig;
  logic [1:0] mode;
  logic       busy;
  logic       wdt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hybrid_jump_sequencer #(
    .DEADTIME (4),
    .MIN_DWELL(8),
    .WDT_LIMIT(20)
  ) dut (
    .i_clock    (clk),
    .i_RESET    (rst),
    .i_enable   (en),
    .i_jump_req (req),
    .i_skip_zero(skip),
    .o_MOSFET   (mos),
    .o_sigma    (sig),
    .o_mode     (mode),
    .o_busy     (busy),
    .o_wdt_flag (wdt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_mos,
                         input logic [1:0] e_sig, input logic [1:0] e_mode,
                         input logic e_busy);
    chk({tag, ".mos"}, mos, e_mos);
    chk({tag, ".sig"}, {2'b00, sig}, {2'b00, e_sig});
    chk({tag, ".mode"}, {2'b00, mode}, {2'b00, e_mode});
    chk({tag, ".busy"}, {3'b000, busy}, {3'b000, e_busy});
  endtask

  // Accept a jump from ARMED, then follow it through DEAD and DWELL back to ARMED.
  task automatic jump(input string tag, input logic [3:0] r, input logic s,
                      input logic [1:0] nm, input logic [3:0] dpat,
                      input logic [3:0] fpat, input logic [1:0] nsig,
                      input logic [1:0] om, input logic [3:0] opat,
                      input logic [1:0] osig);
    req  = r;
    skip = s;
    step();
    req  = 4'b0000;
    skip = !s;
    chk_out({tag, ".pend"}, opat, osig, om, 1'b0);
    step();
    chk_out({tag, ".dead0"}, dpat, nsig, nm, 1'b1);
    repeat (3) begin
      step();
      chk_out({tag, ".dead"}, dpat, nsig, nm, 1'b1);
    end
    step();
    chk_out({tag, ".dwell"}, fpat, nsig, nm, 1'b0);
    repeat (8) step();
    chk_out({tag, ".armed"}, fpat, nsig, nm, 1'b0);
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    req  = 4'b0000;
    skip = 1'b0;
    repeat (2) step();
    chk_out("reset", 4'b0000, 2'b00, 2'd0, 1'b0);
    chk("reset.wdt", {3'b000, wdt}, 4'b0000);

    rst = 1'b0;
    en  = 1'b1;
    req = 4'b1111;
    step();
    chk_out("start.dead0", 4'b0000, 2'b01, 2'd0, 1'b1);
    repeat (3) begin
      step();
      chk_out("start.dead", 4'b0000, 2'b01, 2'd0, 1'b1);
    end
    step();
    chk_out("start.dwell0", 4'b1001, 2'b01, 2'd0, 1'b0);
    repeat (7) begin
      step();
      chk_out("dwell.ignore", 4'b1001, 2'b01, 2'd0, 1'b0);
    end
    step();
    chk_out("dwell.last", 4'b1001, 2'b01, 2'd0, 1'b0);
    req = 4'b0000;
    step();
    chk_out("armed.hold", 4'b1001, 2'b01, 2'd0, 1'b0);

    jump("m0to1", 4'b0001, 1'b0, 2'd1, 4'b0001, 4'b0011, 2'b00,
         2'd0, 4'b1001, 2'b01);

    req = 4'b0001;
    repeat (2) step();
    chk_out("wrongbit", 4'b0011, 2'b00, 2'd1, 1'b0);
    req = 4'b0000;

    jump("m1to2", 4'b0010, 1'b0, 2'd2, 4'b0010, 4'b0110, 2'b11,
         2'd1, 4'b0011, 2'b00);
    jump("m2to3", 4'b0100, 1'b0, 2'd3, 4'b0010, 4'b0011, 2'b00,
         2'd2, 4'b0110, 2'b11);
    jump("m3to0", 4'b1000, 1'b0, 2'd0, 4'b0001, 4'b1001, 2'b01,
         2'd3, 4'b0011, 2'b00);

    jump("skip0to2", 4'b0001, 1'b1, 2'd2, 4'b0000, 4'b0110, 2'b11,
         2'd0, 4'b1001, 2'b01);
    jump("skip2to0", 4'b0100, 1'b1, 2'd0, 4'b0000, 4'b1001, 2'b01,
         2'd2, 4'b0110, 2'b11);

    req = 4'b0001;
    en  = 1'b0;
    step();
    chk_out("disable_on_jump", 4'b0000, 2'b00, 2'd0, 1'b0);
    req = 4'b0000;
    step();
    chk_out("idle_stay", 4'b0000, 2'b00, 2'd0, 1'b0);

    en = 1'b1;
    step();
    chk_out("reen.dead0", 4'b0000, 2'b01, 2'd0, 1'b1);
    rst = 1'b1;
    step();
    chk_out("reset_in_dead", 4'b0000, 2'b00, 2'd0, 1'b0);
    rst = 1'b0;
    step();
    chk_out("restart.dead0", 4'b0000, 2'b01, 2'd0, 1'b1);
    repeat (12) step();
    chk_out("restart.armed", 4'b1001, 2'b01, 2'd0, 1'b0);

    jump("wd_setup", 4'b0001, 1'b0, 2'd1, 4'b0001, 4'b0011, 2'b00,
         2'd0, 4'b1001, 2'b01);

`ifdef HYBRID_JUMP_WATCHDOG_EN
    repeat (20) step();
    chk_out("wd.before", 4'b0011, 2'b00, 2'd1, 1'b0);
    step();
    chk_out("wd.fired", 4'b0010, 2'b11, 2'd2, 1'b1);
    chk("wd.flag", {3'b000, wdt}, 4'b0001);
    repeat (20) step();
    chk("wd.sticky", {3'b000, wdt}, 4'b0001);
    rst = 1'b1;
    step();
    chk("wd.cleared", {3'b000, wdt}, 4'b0000);
    rst = 1'b0;
`else
    repeat (25) step();
    chk_out("nowd.hold", 4'b0011, 2'b00, 2'd1, 1'b0);
    chk("nowd.flag", {3'b000, wdt}, 4'b0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
